// File: rtl/axi_to_axi_lite_burst_pc_pkg.sv
// Shared types and helpers for the AXI4 burst to AXI4-Lite protocol converter.
package axi_to_axi_lite_burst_pc_pkg;

  // Burst type encodings (2'b11 is reserved and handled like INCR).
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Response encodings.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_BEAT,
    W_WAITAW,
    W_WAITW,
    W_BRESP,
    W_RESP
  } w_state_e;

  // Fold one beat response into the burst response: DECERR beats SLVERR beats
  // OKAY, and EXOKAY carries no exclusive meaning across split beats.
  function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] resp);
    if (acc == RESP_DECERR || resp == RESP_DECERR) begin
      return RESP_DECERR;
    end else if (acc == RESP_SLVERR || resp == RESP_SLVERR) begin
      return RESP_SLVERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axi_to_axi_lite_burst_pc_if.sv
// Bus interfaces used by the converter: full AXI4 (burst) and AXI4-Lite.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_valid, input w_ready,
    input b_id, b_resp, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_valid, output w_ready,
    output b_id, b_resp, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_valid;
  logic                      w_ready;

  logic [1:0]                b_resp;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input aw_addr, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_to_axi_lite_burst_pc_addr_gen.sv
// Next-beat address calculation for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import axi_to_axi_lite_burst_pc_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [7:0]                len,
  input  logic [2:0]                size,
  input  logic [1:0]                burst,
  output logic [AXI_ADDR_WIDTH-1:0] next_addr
);

  logic [AXI_ADDR_WIDTH-1:0] step;
  logic [AXI_ADDR_WIDTH-1:0] size_mask;
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
  logic [AXI_ADDR_WIDTH-1:0] aligned;

  // Step to the next size-aligned address; WRAP keeps the container base and
  // only lets the offset inside the (len+1)*2^size window roll over.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    next_addr = addr;
    step      = AXI_ADDR_WIDTH'(1) << size;
    size_mask = step - AXI_ADDR_WIDTH'(1);
    wrap_mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
    aligned   = addr & ~size_mask;
    unique case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((aligned + step) & wrap_mask);
      default:     next_addr = aligned + step;
    endcase
  end

endmodule

// File: rtl/axi_to_axi_lite_burst_pc.sv
// AXI4 burst slave to AXI4-Lite single-beat master; independent read and
// write engines, each handling one burst at a time.
module axi_to_axi_lite_burst_pc
  import axi_to_axi_lite_burst_pc_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10
) (
  input  logic     Clk_CI,
  input  logic     Rst_RI,
  AXI_BUS.Slave    Axi_PS,
  AXI_LITE.Master  AxiLite_PM
);

  // ---------------------------------------------------------------- read path
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_next_addr;
  logic [7:0]                r_len_q, r_cnt_q;
  logic [2:0]                r_size_q;
  logic [1:0]                r_burst_q;
  logic                      r_latch, r_advance, r_last_beat;

  // ---------------------------------------------------------------- write path
  w_state_e                  w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0]   w_id_q;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_next_addr;
  logic [7:0]                w_len_q, w_cnt_q;
  logic [2:0]                w_size_q;
  logic [1:0]                w_burst_q;
  logic [1:0]                w_resp_q;
  logic                      w_latch, w_advance, w_merge, w_last_beat;
  logic [AXI_DATA_WIDTH-1:0] w_data;

  axi_burst_addr_gen #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) i_r_addr_gen (
    .addr      (r_addr_q),
    .len       (r_len_q),
    .size      (r_size_q),
    .burst     (r_burst_q),
    .next_addr (r_next_addr)
  );

  axi_burst_addr_gen #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) i_w_addr_gen (
    .addr      (w_addr_q),
    .len       (w_len_q),
    .size      (w_size_q),
    .burst     (w_burst_q),
    .next_addr (w_next_addr)
  );

  assign r_last_beat = (r_cnt_q == r_len_q);
  assign w_last_beat = (w_cnt_q == w_len_q);

  // Payloads come straight from registers or the opposite bus, so they stay
  // stable for as long as the matching valid is held.
  assign AxiLite_PM.ar_addr = r_addr_q;
  assign Axi_PS.r_id        = r_id_q;
  assign Axi_PS.r_data      = AxiLite_PM.r_data;
  assign Axi_PS.r_resp      = AxiLite_PM.r_resp;
  assign Axi_PS.r_last      = r_last_beat;
  assign Axi_PS.r_user      = '0;

  assign w_data             = Axi_PS.w_data;
  assign AxiLite_PM.aw_addr = w_addr_q;
  assign AxiLite_PM.w_data  = w_data;
  assign AxiLite_PM.w_strb  = Axi_PS.w_strb;
  assign Axi_PS.b_id        = w_id_q;
  assign Axi_PS.b_resp      = w_resp_q;

  // Read state and burst bookkeeping registers.
  always_ff @(posedge Clk_CI) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (Rst_RI) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (r_latch) begin
        r_id_q    <= Axi_PS.ar_id;
        r_addr_q  <= Axi_PS.ar_addr;
        r_len_q   <= Axi_PS.ar_len;
        r_size_q  <= Axi_PS.ar_size;
        r_burst_q <= Axi_PS.ar_burst;
        r_cnt_q   <= '0;
      end else if (r_advance) begin
        r_addr_q <= r_next_addr;
        r_cnt_q  <= r_cnt_q + 8'd1;
      end
    end
  end

  // Read next-state and handshake outputs; everything is quiet during reset.
  always_comb begin
    r_state_d             = r_state_q;
    r_latch               = 1'b0;
    r_advance             = 1'b0;
    Axi_PS.ar_ready       = 1'b0;
    Axi_PS.r_valid        = 1'b0;
    AxiLite_PM.ar_valid   = 1'b0;
    AxiLite_PM.r_ready    = 1'b0;
    if (!Rst_RI) begin
      unique case (r_state_q)
        R_IDLE: begin
          Axi_PS.ar_ready = 1'b1;
          if (Axi_PS.ar_valid) begin
            r_latch   = 1'b1;
            r_state_d = R_ADDR;
          end
        end
        R_ADDR: begin
          AxiLite_PM.ar_valid = 1'b1;
          if (AxiLite_PM.ar_ready) r_state_d = R_DATA;
        end
        R_DATA: begin
          Axi_PS.r_valid     = AxiLite_PM.r_valid;
          AxiLite_PM.r_ready = Axi_PS.r_ready;
          if (AxiLite_PM.r_valid && Axi_PS.r_ready) begin
            if (r_last_beat) begin
              r_state_d = R_IDLE;
            end else begin
              r_advance = 1'b1;
              r_state_d = R_ADDR;
            end
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  // Write state, burst bookkeeping and response accumulator registers.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (w_latch) begin
        w_id_q    <= Axi_PS.aw_id;
        w_addr_q  <= Axi_PS.aw_addr;
        w_len_q   <= Axi_PS.aw_len;
        w_size_q  <= Axi_PS.aw_size;
        w_burst_q <= Axi_PS.aw_burst;
        w_cnt_q   <= '0;
        w_resp_q  <= RESP_OKAY;
      end else begin
        if (w_merge) w_resp_q <= merge_resp(w_resp_q, AxiLite_PM.b_resp);
        if (w_advance) begin
          w_addr_q <= w_next_addr;
          w_cnt_q  <= w_cnt_q + 8'd1;
        end
      end
    end
  end

  // Write next-state and handshake outputs; lite aw and w are offered together
  // and whichever fires first is remembered by the waiting states.
  always_comb begin
    w_state_d           = w_state_q;
    w_latch             = 1'b0;
    w_advance           = 1'b0;
    w_merge             = 1'b0;
    Axi_PS.aw_ready     = 1'b0;
    Axi_PS.w_ready      = 1'b0;
    Axi_PS.b_valid      = 1'b0;
    AxiLite_PM.aw_valid = 1'b0;
    AxiLite_PM.w_valid  = 1'b0;
    AxiLite_PM.b_ready  = 1'b0;
    if (!Rst_RI) begin
      unique case (w_state_q)
        W_IDLE: begin
          Axi_PS.aw_ready = 1'b1;
          if (Axi_PS.aw_valid) begin
            w_latch   = 1'b1;
            w_state_d = W_BEAT;
          end
        end
        W_BEAT: begin
          if (Axi_PS.w_valid) begin
            AxiLite_PM.aw_valid = 1'b1;
            AxiLite_PM.w_valid  = 1'b1;
            Axi_PS.w_ready      = AxiLite_PM.w_ready;
            unique case ({AxiLite_PM.aw_ready, AxiLite_PM.w_ready})
              2'b11:   w_state_d = W_BRESP;
              2'b01:   w_state_d = W_WAITAW;
              2'b10:   w_state_d = W_WAITW;
              default: w_state_d = W_BEAT;
            endcase
          end
        end
        W_WAITAW: begin
          AxiLite_PM.aw_valid = 1'b1;
          if (AxiLite_PM.aw_ready) w_state_d = W_BRESP;
        end
        W_WAITW: begin
          AxiLite_PM.w_valid = Axi_PS.w_valid;
          Axi_PS.w_ready     = Axi_PS.w_valid && AxiLite_PM.w_ready;
          if (Axi_PS.w_valid && AxiLite_PM.w_ready) w_state_d = W_BRESP;
        end
        W_BRESP: begin
          AxiLite_PM.b_ready = 1'b1;
          if (AxiLite_PM.b_valid) begin
            w_merge = 1'b1;
            if (w_last_beat) begin
              w_state_d = W_RESP;
            end else begin
              w_advance = 1'b1;
              w_state_d = W_BEAT;
            end
          end
        end
        W_RESP: begin
          Axi_PS.b_valid = 1'b1;
          if (Axi_PS.b_ready) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_to_axi_lite_burst_pc.sv
// Directed bench for the AXI4 burst to AXI4-Lite converter. Stimulus is
// driven on the falling edge; outputs are sampled 1 time unit later.
module tb_axi_to_axi_lite_burst_pc;
  import axi_to_axi_lite_burst_pc_pkg::*;

  logic clk;
  logic rst;
  int   n_asserts = 0;
  int   n_fails   = 0;

  AXI_BUS #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(1)
  ) axi ();
  AXI_LITE #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) lite ();

  axi_to_axi_lite_burst_pc #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10)
  ) dut (
    .Clk_CI     (clk),
    .Rst_RI     (rst),
    .Axi_PS     (axi),
    .AxiLite_PM (lite)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All valid/ready outputs of the DUT packed together.
  function automatic logic [9:0] dut_handshakes();
    return {axi.aw_ready, axi.w_ready, axi.b_valid, axi.ar_ready, axi.r_valid,
            lite.aw_valid, lite.w_valid, lite.b_ready, lite.ar_valid, lite.r_ready};
  endfunction

  task automatic axi_ar(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    axi.ar_valid = 1'b1; axi.ar_id = id; axi.ar_addr = addr;
    axi.ar_len = len; axi.ar_size = size; axi.ar_burst = burst;
    #1 check("ar_ready", axi.ar_ready, 1);
    @(negedge clk);
    axi.ar_valid = 1'b0;
  endtask

  task automatic lite_ar(input string tag, input logic [31:0] exp_addr);
    lite.ar_ready = 1'b1;
    #1;
    check({tag, ".ar_valid"}, lite.ar_valid, 1);
    check({tag, ".ar_addr"}, lite.ar_addr, exp_addr);
    check({tag, ".r_valid_early"}, axi.r_valid, 0);
    @(negedge clk);
    lite.ar_ready = 1'b0;
  endtask

  task automatic lite_r(input string tag, input logic [63:0] data, input logic [1:0] resp,
                        input logic [9:0] exp_id, input logic exp_last);
    lite.r_valid = 1'b1; lite.r_data = data; lite.r_resp = resp; axi.r_ready = 1'b1;
    #1;
    check({tag, ".r_valid"}, axi.r_valid, 1);
    check({tag, ".r_id"}, axi.r_id, exp_id);
    check({tag, ".r_data"}, axi.r_data, data);
    check({tag, ".r_resp"}, axi.r_resp, resp);
    check({tag, ".r_last"}, axi.r_last, exp_last);
    check({tag, ".r_user"}, axi.r_user, 0);
    check({tag, ".r_ready"}, lite.r_ready, 1);
    @(negedge clk);
    lite.r_valid = 1'b0; axi.r_ready = 1'b0;
  endtask

  task automatic read_burst(input string tag, input logic [9:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [31:0] exp_addr [4]);
    axi_ar(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      lite_ar($sformatf("%s.b%0d", tag, i), exp_addr[i]);
      lite_r($sformatf("%s.b%0d", tag, i), 64'hD0D0_0000_0000_0000 | 64'(i),
             (i == 1) ? RESP_SLVERR : RESP_OKAY, id, (i == int'(len)));
    end
    #1 check({tag, ".idle"}, axi.ar_ready, 1);
    @(negedge clk);
  endtask

  task automatic axi_aw(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    axi.aw_valid = 1'b1; axi.aw_id = id; axi.aw_addr = addr;
    axi.aw_len = len; axi.aw_size = size; axi.aw_burst = burst;
    #1 check("aw_ready", axi.aw_ready, 1);
    @(negedge clk);
    axi.aw_valid = 1'b0;
  endtask

  task automatic write_beat(input string tag, input logic [31:0] exp_addr,
                            input logic [63:0] data, input logic [7:0] strb, input logic last);
    axi.w_valid = 1'b1; axi.w_data = data; axi.w_strb = strb; axi.w_last = last;
    lite.aw_ready = 1'b1; lite.w_ready = 1'b1;
    #1;
    check({tag, ".aw_valid"}, lite.aw_valid, 1);
    check({tag, ".aw_addr"}, lite.aw_addr, exp_addr);
    check({tag, ".w_valid"}, lite.w_valid, 1);
    check({tag, ".w_data"}, lite.w_data, data);
    check({tag, ".w_strb"}, lite.w_strb, strb);
    check({tag, ".w_ready"}, axi.w_ready, 1);
    @(negedge clk);
    axi.w_valid = 1'b0; axi.w_last = 1'b0; lite.aw_ready = 1'b0; lite.w_ready = 1'b0;
  endtask

  task automatic lite_b(input string tag, input logic [1:0] resp);
    lite.b_valid = 1'b1; lite.b_resp = resp;
    #1;
    check({tag, ".b_ready"}, lite.b_ready, 1);
    check({tag, ".no_dup_aw"}, lite.aw_valid, 0);
    check({tag, ".no_early_b"}, axi.b_valid, 0);
    @(negedge clk);
    lite.b_valid = 1'b0;
  endtask

  task automatic axi_b(input string tag, input logic [9:0] exp_id, input logic [1:0] exp_resp);
    axi.b_ready = 1'b1;
    #1;
    check({tag, ".b_valid"}, axi.b_valid, 1);
    check({tag, ".b_id"}, axi.b_id, exp_id);
    check({tag, ".b_resp"}, axi.b_resp, exp_resp);
    @(negedge clk);
    axi.b_ready = 1'b0;
    #1;
    check({tag, ".b_done"}, axi.b_valid, 0);
    check({tag, ".aw_idle"}, axi.aw_ready, 1);
    @(negedge clk);
  endtask

  logic [31:0] exp_a [4];

  initial begin
    rst = 1'b1;
    axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = '0; axi.aw_burst = '0;
    axi.aw_valid = 1'b0; axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b0;
    axi.w_valid = 1'b0; axi.b_ready = 1'b0;
    axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = '0; axi.ar_burst = '0;
    axi.ar_valid = 1'b0; axi.r_ready = 1'b0;
    lite.aw_ready = 1'b0; lite.w_ready = 1'b0; lite.b_resp = '0; lite.b_valid = 1'b0;
    lite.ar_ready = 1'b0; lite.r_data = '0; lite.r_resp = '0; lite.r_valid = 1'b0;

    // Reset: every handshake output low, even with requests pending.
    repeat (2) @(negedge clk);
    axi.ar_valid = 1'b1; axi.aw_valid = 1'b1;
    #1 check("reset.handshakes", 64'(dut_handshakes()), 0);
    @(negedge clk);
    axi.ar_valid = 1'b0; axi.aw_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("reset.ar_ready", axi.ar_ready, 1);
    check("reset.aw_ready", axi.aw_ready, 1);
    check("reset.b_id", axi.b_id, 0);
    check("reset.b_resp", axi.b_resp, RESP_OKAY);
    @(negedge clk);

    // INCR read: 0x1004 len 3 size 2.
    exp_a = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
    read_burst("incr_rd", 10'h2C7, 32'h1004, 8'd3, 3'd2, BURST_INCR, exp_a);

    // WRAP read: 0x38 len 3 size 3 wraps at the 32-byte container.
    exp_a = '{32'h38, 32'h20, 32'h28, 32'h30};
    read_burst("wrap_rd", 10'h013, 32'h38, 8'd3, 3'd3, BURST_WRAP, exp_a);

    // Unaligned INCR start realigns on the second beat; reserved type acts as INCR.
    exp_a = '{32'h1006, 32'h1008, 32'h0, 32'h0};
    read_burst("unal_rd", 10'h001, 32'h1006, 8'd1, 3'd2, 2'b11, exp_a);

    // FIXED write: three beats at 0x200, SLVERR in the middle wins.
    axi_aw(10'h0A5, 32'h200, 8'd2, 3'd3, BURST_FIXED);
    write_beat("fix_wr.b0", 32'h200, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    lite_b("fix_wr.b0", RESP_OKAY);
    write_beat("fix_wr.b1", 32'h200, 64'h5555_6666_7777_8888, 8'h0F, 1'b0);
    lite_b("fix_wr.b1", RESP_SLVERR);
    write_beat("fix_wr.b2", 32'h200, 64'h9999_AAAA_BBBB_CCCC, 8'hF0, 1'b0);
    lite_b("fix_wr.b2", RESP_OKAY);
    axi_b("fix_wr", 10'h0A5, RESP_SLVERR);

    // Lite aw_ready lags w_ready by 3 cycles on a single-beat write.
    axi_aw(10'h111, 32'h300, 8'd0, 3'd2, BURST_INCR);
    axi.w_valid = 1'b1; axi.w_data = 64'hCAFE; axi.w_strb = 8'h0F;
    lite.w_ready = 1'b1; lite.aw_ready = 1'b0;
    #1;
    check("lag.c0.w_ready", axi.w_ready, 1);
    check("lag.c0.aw_valid", lite.aw_valid, 1);
    check("lag.c0.aw_addr", lite.aw_addr, 32'h300);
    @(negedge clk);
    axi.w_valid = 1'b0; lite.w_ready = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      check($sformatf("lag.c%0d.w_ready", c), axi.w_ready, 0);
      check($sformatf("lag.c%0d.w_valid", c), lite.w_valid, 0);
      check($sformatf("lag.c%0d.aw_valid", c), lite.aw_valid, 1);
      check($sformatf("lag.c%0d.aw_addr", c), lite.aw_addr, 32'h300);
      @(negedge clk);
    end
    lite.aw_ready = 1'b1;
    #1;
    check("lag.c3.aw_valid", lite.aw_valid, 1);
    check("lag.c3.aw_addr", lite.aw_addr, 32'h300);
    check("lag.c3.w_ready", axi.w_ready, 0);
    @(negedge clk);
    lite.aw_ready = 1'b0;
    lite_b("lag", RESP_OKAY);
    axi_b("lag", 10'h111, RESP_OKAY);

    // Concurrent len-0 read and write requests in the same cycle.
    axi.ar_valid = 1'b1; axi.ar_id = 10'h155; axi.ar_addr = 32'h600;
    axi.ar_len = 8'd0; axi.ar_size = 3'd3; axi.ar_burst = BURST_INCR;
    axi.aw_valid = 1'b1; axi.aw_id = 10'h2AA; axi.aw_addr = 32'h700;
    axi.aw_len = 8'd0; axi.aw_size = 3'd3; axi.aw_burst = BURST_INCR;
    #1;
    check("conc.ar_ready", axi.ar_ready, 1);
    check("conc.aw_ready", axi.aw_ready, 1);
    @(negedge clk);
    axi.ar_valid = 1'b0; axi.aw_valid = 1'b0;
    lite.ar_ready = 1'b1; lite.aw_ready = 1'b1; lite.w_ready = 1'b1;
    axi.w_valid = 1'b1; axi.w_data = 64'hBEEF; axi.w_strb = 8'hFF;
    #1;
    check("conc.lite_ar_valid", lite.ar_valid, 1);
    check("conc.lite_ar_addr", lite.ar_addr, 32'h600);
    check("conc.lite_aw_valid", lite.aw_valid, 1);
    check("conc.lite_aw_addr", lite.aw_addr, 32'h700);
    check("conc.w_ready", axi.w_ready, 1);
    @(negedge clk);
    lite.ar_ready = 1'b0; lite.aw_ready = 1'b0; lite.w_ready = 1'b0; axi.w_valid = 1'b0;
    lite.r_valid = 1'b1; lite.r_data = 64'h600D; lite.r_resp = RESP_OKAY; axi.r_ready = 1'b1;
    lite.b_valid = 1'b1; lite.b_resp = RESP_OKAY;
    #1;
    check("conc.r_valid", axi.r_valid, 1);
    check("conc.r_id", axi.r_id, 10'h155);
    check("conc.r_last", axi.r_last, 1);
    check("conc.b_ready", lite.b_ready, 1);
    @(negedge clk);
    lite.r_valid = 1'b0; axi.r_ready = 1'b0; lite.b_valid = 1'b0;
    #1 check("conc.rd_idle", axi.ar_ready, 1);
    @(negedge clk);
    axi_b("conc", 10'h2AA, RESP_OKAY);

    // Reset during beat 2 of an 8-beat INCR write.
    axi_aw(10'h3C3, 32'h400, 8'd7, 3'd2, BURST_INCR);
    write_beat("rst_wr.b0", 32'h400, 64'h0A, 8'h0F, 1'b0);
    lite_b("rst_wr.b0", RESP_OKAY);
    axi.w_valid = 1'b1; axi.w_data = 64'h0B; axi.w_strb = 8'h0F;
    #1;
    check("rst_wr.b1.aw_valid", lite.aw_valid, 1);
    check("rst_wr.b1.aw_addr", lite.aw_addr, 32'h404);
    @(negedge clk);
    rst = 1'b1;
    lite.aw_ready = 1'b1; lite.w_ready = 1'b1; lite.b_valid = 1'b1; axi.b_ready = 1'b1;
    #1 check("rst_wr.asserted", 64'(dut_handshakes()), 0);
    @(negedge clk);
    #1 check("rst_wr.next_cycle", 64'(dut_handshakes()), 0);
    @(negedge clk);
    axi.w_valid = 1'b0; lite.aw_ready = 1'b0; lite.w_ready = 1'b0;
    lite.b_valid = 1'b0; axi.b_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_wr.aw_ready", axi.aw_ready, 1);
    check("rst_wr.quiet", lite.aw_valid, 0);
    @(negedge clk);

    // Fresh burst after reset; EXOKAY beats merge to OKAY.
    axi_aw(10'h07E, 32'h500, 8'd1, 3'd2, BURST_INCR);
    write_beat("post.b0", 32'h500, 64'h77, 8'h0F, 1'b0);
    lite_b("post.b0", RESP_EXOKAY);
    write_beat("post.b1", 32'h504, 64'h88, 8'hF0, 1'b0);
    lite_b("post.b1", RESP_EXOKAY);
    axi_b("post", 10'h07E, RESP_OKAY);

    // DECERR outranks an earlier SLVERR.
    axi_aw(10'h3FF, 32'h800, 8'd1, 3'd3, BURST_INCR);
    write_beat("dec.b0", 32'h800, 64'h1, 8'hFF, 1'b0);
    lite_b("dec.b0", RESP_SLVERR);
    write_beat("dec.b1", 32'h808, 64'h2, 8'hFF, 1'b1);
    lite_b("dec.b1", RESP_DECERR);
    axi_b("dec", 10'h3FF, RESP_DECERR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
